// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a held byte, valid/ack
// handshake, sticky frame/overrun flags and a level interrupt.
module uart_rx #(
    parameter int unsigned sys_clk = 50000000,
    parameter int unsigned baud    = 9600
) (
    input  logic        clock,
    input  logic        nRst,
    input  logic        RX,
    input  logic        rx_ack,
    output logic [31:0] data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        interrupt
);

    localparam int unsigned BIT_CNT  = sys_clk / baud - 1;
    localparam int unsigned HALF_CNT = (sys_clk / baud) / 2 - 1;
    localparam logic [31:0] BIT_LIM  = 32'(BIT_CNT);
    localparam logic [31:0] HALF_LIM = 32'(HALF_CNT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic        rx_m, rx_s, rx_p;
    logic [31:0] freq_div_counter, cnt_n;
    logic [2:0]  data_counter, dcnt_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  data_q, data_n;
    logic        valid_n, ferr_n, ovr_n;

    // Two-flop synchroniser plus previous-value flop for edge detect.
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    // State, counters, shift register and CPU-visible registers.
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state            <= IDLE;
            freq_div_counter <= '0;
            data_counter     <= '0;
            shift            <= '0;
            data_q           <= '0;
            rx_valid         <= 1'b0;
            frame_err        <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            state            <= state_n;
            freq_div_counter <= cnt_n;
            data_counter     <= dcnt_n;
            shift            <= shift_n;
            data_q           <= data_n;
            rx_valid         <= valid_n;
            frame_err        <= ferr_n;
            overrun          <= ovr_n;
        end
    end

    // Next-state logic; ack clears first so a same-cycle set wins.
    always_comb begin
        state_n = state;
        cnt_n   = freq_div_counter;
        dcnt_n  = data_counter;
        shift_n = shift;
        data_n  = data_q;
        valid_n = rx_valid;
        ferr_n  = frame_err;
        ovr_n   = overrun;
        if (rx_ack) begin
            valid_n = 1'b0;
            ferr_n  = 1'b0;
            ovr_n   = 1'b0;
        end
        case (state)
            IDLE: begin
                if (rx_p && !rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (freq_div_counter == HALF_LIM) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        dcnt_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = freq_div_counter + 32'd1;
                end
            end
            DATA: begin
                if (freq_div_counter == BIT_LIM) begin
                    shift_n[data_counter] = rx_s;
                    cnt_n  = '0;
                    dcnt_n = data_counter + 3'd1;
                    if (data_counter == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = freq_div_counter + 32'd1;
                end
            end
            STOP: begin
                if (freq_div_counter == BIT_LIM) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        if (!rx_valid || rx_ack) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                        end else begin
                            ovr_n = 1'b1;
                        end
                    end else begin
                        ferr_n = 1'b1;
                    end
                end else begin
                    cnt_n = freq_div_counter + 32'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign data      = {24'd0, data_q};
    assign interrupt = rx_valid | frame_err | overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame vectors plus hand sequences for
// break, glitch and mid-frame reset.
module tb_uart_rx;

    logic        clock = 1'b0;
    logic        nRst = 1'b0;
    logic        RX = 1'b1;
    logic        rx_ack = 1'b0;
    logic [31:0] data;
    logic        rx_valid, frame_err, overrun, interrupt;

    int checks = 0;
    int failures = 0;

    uart_rx #(.sys_clk(160), .baud(10)) dut (
        .clock(clock),
        .nRst(nRst),
        .RX(RX),
        .rx_ack(rx_ack),
        .data(data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .overrun(overrun),
        .interrupt(interrupt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] din;
        logic       stop;
        logic       ack_stop;
        logic       ack_after;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    vec_t tbl[6];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clock);
        #1;
    endtask

    // One frame, 16 cycles per bit; optional ack on the stop-sample
    // cycle (edge 155 after the start bit) and optional early abort
    // by reset.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic ack_stop, input int abort_at);
        for (int c = 0; c < 160; c++) begin
            @(posedge clock);
            #1;
            if (c == abort_at) begin
                nRst = 1'b0;
                RX = 1'b1;
                rx_ack = 1'b0;
                return;
            end
            if (c / 16 == 0) RX = 1'b0;
            else if (c / 16 == 9) RX = stop;
            else RX = b[c/16-1];
            rx_ack = (ack_stop && c == 154);
        end
        rx_ack = 1'b0;
    endtask

    task automatic pulse_ack();
        @(posedge clock);
        #1 rx_ack = 1'b1;
        @(posedge clock);
        #1 rx_ack = 1'b0;
    endtask

    task automatic run_vec(input vec_t t);
        send_frame(t.din, t.stop, t.ack_stop, -1);
        chk($sformatf("data_%h", t.din), data, {24'd0, t.exp_data});
        chk($sformatf("valid_%h", t.din), 32'(rx_valid), 32'(t.exp_valid));
        chk($sformatf("ferr_%h", t.din), 32'(frame_err), 32'(t.exp_fe));
        chk($sformatf("ovr_%h", t.din), 32'(overrun), 32'(t.exp_ov));
        chk($sformatf("irq_%h", t.din), 32'(interrupt),
            32'(t.exp_valid | t.exp_fe | t.exp_ov));
        if (t.ack_after) begin
            pulse_ack();
            chk("ack_valid", 32'(rx_valid), 32'd0);
            chk("ack_ferr", 32'(frame_err), 32'd0);
            chk("ack_ovr", 32'(overrun), 32'd0);
            chk("ack_irq", 32'(interrupt), 32'd0);
            chk("ack_data", data, {24'd0, t.exp_data});
        end
    endtask

    initial begin
        //            din   stp   aks   aka   exp   v     fe    ov
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h81, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};

        cycles(3);
        chk("rst_data", data, 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_irq", 32'(interrupt), 32'd0);
        nRst = 1'b1;
        cycles(20);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Line held low (break): no further frames.
        cycles(40 * 16);
        chk("brk_valid", 32'(rx_valid), 32'd0);
        chk("brk_data", data, 32'h55);
        chk("brk_ferr", 32'(frame_err), 32'd1);
        RX = 1'b1;
        cycles(32);
        chk("brk_rel_valid", 32'(rx_valid), 32'd0);
        pulse_ack();
        chk("brk_ack_ferr", 32'(frame_err), 32'd0);
        chk("brk_ack_irq", 32'(interrupt), 32'd0);

        // Short glitch is rejected as a false start.
        RX = 1'b0;
        cycles(4);
        RX = 1'b1;
        cycles(40);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        chk("glitch_irq", 32'(interrupt), 32'd0);
        v = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        run_vec(v);

        // Reset after three data bits of a 0xFF frame.
        send_frame(8'hFF, 1'b1, 1'b0, 64);
        cycles(3);
        chk("mrst_data", data, 32'd0);
        chk("mrst_valid", 32'(rx_valid), 32'd0);
        chk("mrst_ferr", 32'(frame_err), 32'd0);
        chk("mrst_ovr", 32'(overrun), 32'd0);
        chk("mrst_irq", 32'(interrupt), 32'd0);
        nRst = 1'b1;
        cycles(200);
        chk("mrst_idle_valid", 32'(rx_valid), 32'd0);
        v = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        run_vec(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
